// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite slave write path: response codes and
// the write-commit state encoding (also used by the W channel stage).
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } wr_state_e;

endpackage

// File: rtl/axil_write_resp_timer.sv
// Memory-ack timeout counter. Cleared while the write is issued, counts
// every WAIT cycle and saturates at TIMEOUT.
module axil_wr_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins over enable, saturate so a long stall never wraps.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expires in the WAIT cycle whose increment brings the count to TIMEOUT-1,
    // so the response lands exactly TIMEOUT cycles after the write was issued.
    assign expire = (int'(count_q) + 2) >= TIMEOUT;

endmodule

// File: rtl/axil_write_resp.sv
// Write-commit and response stage of the AXI4-Lite slave. Joins the AW address
// with W data/strobes, performs one strobed memory write, waits for the ack
// (bounded by TIMEOUT) and returns BRESP on the B channel and to the W stage.
//
// state | meaning
// IDLE  | capturing address/data; decodes once both are held
// ISSUE | MEM_WEN high for one cycle with the captured write
// WAIT  | waiting for MEM_ACK or the timeout
// RESP  | BVALID high with a stable BRESP until BREADY
module axil_write_resp
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = 4,
    parameter int MEM_DEPTH  = 256,
    parameter int TIMEOUT    = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         ADDRREADY,
    input  logic [ADDR_WIDTH-1:0]        WADDR,
    input  logic                         DATAREADY,
    input  logic [DATA_WIDTH-1:0]        WDATAIN,
    input  logic [STRB_WIDTH-1:0]        WSTRBIN,
    output logic                         MEM_WEN,
    output logic [$clog2(MEM_DEPTH)-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0]        MEM_WDATA,
    output logic [STRB_WIDTH-1:0]        MEM_WSTRB,
    input  logic                         MEM_ACK,
    input  logic                         MEM_ERR,
    output logic                         BVALID,
    input  logic                         BREADY,
    output logic [1:0]                   BRESP,
    output logic                         BRESPREADY
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int LSB   = $clog2(STRB_WIDTH);

    wr_state_e               state_q, state_d;
    logic                    a_vld_q, a_vld_d;
    logic                    d_vld_q, d_vld_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [STRB_WIDTH-1:0]   strb_q, strb_d;
    logic                    mem_wen_q, mem_wen_d;
    logic [IDX_W-1:0]        mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_WIDTH-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;

    logic [ADDR_WIDTH-1:0]   word_idx;
    logic                    dec_err;
    logic                    misalign;
    logic                    tmr_clr;
    logic                    tmr_en;
    logic                    tmr_expire;

    assign word_idx = addr_q >> LSB;
    assign dec_err  = word_idx >= ADDR_WIDTH'(MEM_DEPTH);
    assign misalign = (addr_q & ADDR_WIDTH'(STRB_WIDTH - 1)) != '0;
    assign tmr_clr  = (state_q == ST_ISSUE);
    assign tmr_en   = (state_q == ST_WAIT);

    axil_wr_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .resetn (resetn),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

    // Next state, capture registers and registered outputs; outputs default to 0.
    always_comb begin
        state_d     = state_q;
        a_vld_d     = a_vld_q;
        d_vld_d     = d_vld_q;
        addr_d      = addr_q;
        data_d      = data_q;
        strb_d      = strb_q;
        mem_wen_d   = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_wstrb_d = '0;
        bvalid_d    = 1'b0;
        bresp_d     = RESP_OKAY;
        case (state_q)
            ST_IDLE: begin
                if (!a_vld_q && ADDRREADY) begin
                    addr_d  = WADDR;
                    a_vld_d = 1'b1;
                end
                if (!d_vld_q && DATAREADY) begin
                    data_d  = WDATAIN;
                    strb_d  = WSTRBIN;
                    d_vld_d = 1'b1;
                end
                if (a_vld_q && d_vld_q) begin
                    if (dec_err) begin
                        state_d  = ST_RESP;
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_DECERR;
                    end else if (misalign) begin
                        state_d  = ST_RESP;
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_SLVERR;
                    end else if (strb_q == '0) begin
                        state_d  = ST_RESP;
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_OKAY;
                    end else begin
                        state_d     = ST_ISSUE;
                        mem_wen_d   = 1'b1;
                        mem_addr_d  = word_idx[IDX_W-1:0];
                        mem_wdata_d = data_q;
                        mem_wstrb_d = strb_q;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (MEM_ACK) begin
                    state_d  = ST_RESP;
                    bvalid_d = 1'b1;
                    bresp_d  = MEM_ERR ? RESP_SLVERR : RESP_OKAY;
                end else if (tmr_expire) begin
                    state_d  = ST_RESP;
                    bvalid_d = 1'b1;
                    bresp_d  = RESP_SLVERR;
                end
            end
            ST_RESP: begin
                if (BREADY) begin
                    state_d = ST_IDLE;
                    a_vld_d = 1'b0;
                    d_vld_d = 1'b0;
                end else begin
                    bvalid_d = 1'b1;
                    bresp_d  = bresp_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, capture and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            a_vld_q     <= 1'b0;
            d_vld_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            strb_q      <= '0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            a_vld_q     <= a_vld_d;
            d_vld_q     <= d_vld_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            strb_q      <= strb_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
        end
    end

    assign MEM_WEN    = mem_wen_q;
    assign MEM_ADDR   = mem_addr_q;
    assign MEM_WDATA  = mem_wdata_q;
    assign MEM_WSTRB  = mem_wstrb_q;
    assign BVALID     = bvalid_q;
    assign BRESP      = bresp_q;
    // The W stage must see the final code in the handshake cycle itself.
    assign BRESPREADY = (state_q == ST_RESP) && BREADY;

endmodule

// File: tb/tb_axil_write_resp.sv
// Scoreboard bench for axil_write_resp: expected memory writes and responses
// are queued when a transaction is driven and checked as the DUT produces them.
module tb_axil_write_resp;

    localparam int         TIMEOUT  = 16;
    localparam logic [1:0] B_OKAY   = 2'b00;
    localparam logic [1:0] B_SLVERR = 2'b10;
    localparam logic [1:0] B_DECERR = 2'b11;

    typedef struct {
        logic [7:0]  idx;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ADDRREADY = 1'b0;
    logic [31:0] WADDR = '0;
    logic        DATAREADY = 1'b0;
    logic [31:0] WDATAIN = '0;
    logic [3:0]  WSTRBIN = '0;
    logic        MEM_WEN;
    logic [7:0]  MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [3:0]  MEM_WSTRB;
    logic        MEM_ACK;
    logic        MEM_ERR;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [1:0]  BRESP;
    logic        BRESPREADY;

    logic ack_r = 1'b0, ack_e_r = 1'b0, man_ack = 1'b0;
    assign MEM_ACK = ack_r | man_ack;
    assign MEM_ERR = ack_e_r;

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    int wen_cnt = 0, wen_cyc = 0, bv_cyc = 0, done_cnt = 0, n_cyc = 0;
    int bv_wait = 0;
    int ack_delay = 1;
    bit ack_err = 1'b0;
    int bready_delay = 0;
    logic       prev_bv = 1'b0, prev_br = 1'b0;
    logic [1:0] prev_bresp = '0;
    wr_t        exp_wr[$];
    logic [1:0] exp_resp[$];

    axil_write_resp #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4), .MEM_DEPTH(256), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .resetn(resetn),
        .ADDRREADY(ADDRREADY), .WADDR(WADDR),
        .DATAREADY(DATAREADY), .WDATAIN(WDATAIN), .WSTRBIN(WSTRBIN),
        .MEM_WEN(MEM_WEN), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WSTRB(MEM_WSTRB),
        .MEM_ACK(MEM_ACK), .MEM_ERR(MEM_ERR),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BRESPREADY(BRESPREADY)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory model: acks ack_delay cycles after the write cycle (never if negative).
    initial forever begin
        @(negedge clk);
        if (resetn && MEM_WEN && ack_delay >= 0) begin
            repeat (ack_delay) @(posedge clk);
            #1;
            ack_r   = 1'b1;
            ack_e_r = ack_err;
            @(posedge clk);
            #1;
            ack_r   = 1'b0;
            ack_e_r = 1'b0;
        end
    end

    // B channel master: BREADY held low for bready_delay BVALID cycles.
    initial forever begin
        @(posedge clk);
        #2;
        BREADY = (bv_wait >= bready_delay);
    end

    // Monitor / scoreboard, sampled mid-cycle.
    initial forever begin
        wr_t e;
        logic [1:0] r;
        @(negedge clk);
        if (!resetn) begin
            prev_bv = 1'b0;
            prev_br = 1'b0;
            bv_wait = 0;
        end else begin
            if (MEM_WEN) begin
                wen_cnt++;
                wen_cyc = cyc;
                chk("wr_expected", 64'(exp_wr.size() != 0), 1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    chk("mem_addr", MEM_ADDR, e.idx);
                    chk("mem_wdata", MEM_WDATA, e.data);
                    chk("mem_wstrb", MEM_WSTRB, e.strb);
                end
            end else begin
                chk("mem_bus_idle", {MEM_ADDR, MEM_WDATA, MEM_WSTRB}, 0);
            end
            if (BVALID && !prev_bv) bv_cyc = cyc;
            if (prev_bv && !prev_br) begin
                chk("bvalid_hold", BVALID, 1);
                chk("bresp_hold", BRESP, prev_bresp);
            end
            if (!BVALID) chk("bresp_idle", BRESP, 0);
            chk("brespready", BRESPREADY, BVALID && BREADY);
            if (BVALID) bv_wait++;
            if (BVALID && BREADY) begin
                done_cnt++;
                bv_wait = 0;
                chk("resp_expected", 64'(exp_resp.size() != 0), 1);
                if (exp_resp.size() != 0) begin
                    r = exp_resp.pop_front();
                    chk("bresp", BRESP, r);
                end
            end
            prev_bv    = BVALID;
            prev_br    = BREADY;
            prev_bresp = BRESP;
        end
    end

    // Data may lead the address by `lead` cycles; later data values are junk
    // that must be ignored. Records the cycle in which the last valid rose.
    task automatic drive(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int lead);
        DATAREADY = 1'b1;
        WDATAIN   = data;
        WSTRBIN   = strb;
        if (lead > 0) begin
            @(posedge clk);
            #1;
            WDATAIN = ~data;
            WSTRBIN = ~strb;
            repeat (lead - 1) begin
                @(posedge clk);
                #1;
            end
            DATAREADY = 1'b0;
        end
        ADDRREADY = 1'b1;
        WADDR     = addr;
        n_cyc     = cyc;
        @(posedge clk);
        #1;
        ADDRREADY = 1'b0;
        DATAREADY = 1'b0;
        WADDR     = ~addr;
        WDATAIN   = '0;
        WSTRBIN   = '0;
    endtask

    task automatic wait_done(input int base, input string tag);
        int k = 0;
        while (done_cnt == base && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, "_done"}, 64'(done_cnt - base), 1);
    endtask

    task automatic run_txn(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int lead, input int ack_d, input bit ack_e,
                           input int brd, input logic [1:0] exp_b, input bit exp_w, input int lat_bv);
        int bw, bd;
        ack_delay    = ack_d;
        ack_err      = ack_e;
        bready_delay = brd;
        @(posedge clk);
        #1;
        if (exp_w) exp_wr.push_back('{addr[9:2], data, strb});
        exp_resp.push_back(exp_b);
        bw = wen_cnt;
        bd = done_cnt;
        drive(addr, data, strb, lead);
        wait_done(bd, tag);
        chk({tag, "_wen_cnt"}, 64'(wen_cnt - bw), 64'(exp_w));
        if (exp_w) chk({tag, "_wen_lat"}, 64'(wen_cyc - n_cyc), 2);
        chk({tag, "_bv_lat"}, 64'(bv_cyc - n_cyc), 64'(lat_bv));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int bd;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {MEM_WEN, MEM_ADDR, MEM_WDATA, MEM_WSTRB, BVALID, BRESP, BRESPREADY}, 0);
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        //      tag          addr          data          strb  lead ack_d    err brd resp      wr lat_bv
        run_txn("basic",     32'h10,       32'hDEADBEEF, 4'hF, 0,   1,       0,  0,  B_OKAY,   1, 4);
        run_txn("lead3",     32'h20,       32'h12345678, 4'h5, 3,   2,       0,  0,  B_OKAY,   1, 5);
        run_txn("decerr",    32'h400,      32'h11111111, 4'hF, 0,   1,       0,  0,  B_DECERR, 0, 2);
        run_txn("dec_prio",  32'h401,      32'h22222222, 4'h0, 0,   1,       0,  0,  B_DECERR, 0, 2);
        run_txn("misalign",  32'h13,       32'h33333333, 4'hF, 0,   1,       0,  0,  B_SLVERR, 0, 2);
        run_txn("strb0",     32'h08,       32'h44444444, 4'h0, 1,   1,       0,  0,  B_OKAY,   0, 2);
        run_txn("timeout",   32'h30,       32'h55555555, 4'hC, 0,   -1,      0,  0,  B_SLVERR, 1, 2 + TIMEOUT);
        run_txn("memerr",    32'h34,       32'h66666666, 4'h3, 0,   3,       1,  0,  B_SLVERR, 1, 6);
        run_txn("ack_last",  32'h38,       32'h77777777, 4'hF, 0,   TIMEOUT - 1, 0, 0, B_OKAY, 1, 2 + TIMEOUT);
        run_txn("ack_late",  32'h3C,       32'h88888888, 4'hF, 0,   TIMEOUT, 0,  0,  B_SLVERR, 1, 2 + TIMEOUT);
        run_txn("bready5",   32'h3FC,      32'h99999999, 4'hA, 2,   1,       0,  5,  B_OKAY,   1, 4);
        run_txn("retry",     32'h3C,       32'h88888888, 4'hF, 0,   1,       0,  0,  B_OKAY,   1, 4);

        // Reset while waiting for the ack: write is aborted without any response.
        ack_delay    = -1;
        bready_delay = 0;
        @(posedge clk);
        #1;
        exp_wr.push_back('{8'h05, 32'hCAFEF00D, 4'hF});
        bd = done_cnt;
        drive(32'h14, 32'hCAFEF00D, 4'hF, 0);
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("rst_wait_outputs", {MEM_WEN, MEM_ADDR, MEM_WDATA, MEM_WSTRB, BVALID, BRESP, BRESPREADY}, 0);
        repeat (2) @(posedge clk);
        #1;
        resetn  = 1'b1;
        man_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        man_ack = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_resp", 64'(done_cnt - bd), 0);
        chk("abort_bvalid", BVALID, 0);

        run_txn("post_rst",  32'h18,       32'h0BADCAFE, 4'hF, 0,   1,       0,  0,  B_OKAY,   1, 4);

        chk("left_writes", 64'(exp_wr.size()), 0);
        chk("left_resps", 64'(exp_resp.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
